brancher_stack: RTL

Parametrised successor to the team's brancher program-counter unit. It adds:
- configurable PC and flag widths;
- absolute and signed-relative conditional branches;
- conditional skip;
- a hardware call/return stack of configurable depth, with a sticky fault flag.

It sits between the instruction decoder (which issues strobed ops) and instruction fetch (which consumes tx_program_counter).

---
 rtl/brancher_stack.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/brancher_stack.sv
// Program-counter unit with conditional absolute/relative branches, skip,
// and a hardware call/return stack with a sticky fault flag.
module brancher_stack #(
   parameter int PC_WIDTH    = 16,
   parameter int FLAG_WIDTH  = 4,
   parameter int STACK_DEPTH = 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  rx_enable,
   input  logic                  rx_strobe,
   input  logic [2:0]            rx_op,
   input  logic [FLAG_WIDTH-1:0] rx_input_flags,
   input  logic [FLAG_WIDTH-1:0] rx_check_flags,
   input  logic [PC_WIDTH-1:0]   rx_branch,
   output logic [PC_WIDTH-1:0]   tx_program_counter,
   output logic                  tx_ready,
   output logic                  tx_fault
);

   localparam int AW  = $clog2(STACK_DEPTH);
   localparam int SPW = AW + 1;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_WFLAGS = 3'b001;
   localparam logic [2:0] OP_JABS   = 3'b010;
   localparam logic [2:0] OP_JREL   = 3'b011;
   localparam logic [2:0] OP_CALL   = 3'b100;
   localparam logic [2:0] OP_RET    = 3'b101;
   localparam logic [2:0] OP_SKIP   = 3'b110;

   typedef enum logic {IDLE, EXEC} state_t;

   // Handshake: an op is taken on a rising edge where rx_enable, rx_strobe and
   // tx_ready are all high; tx_ready stays low until the op has executed.
   state_t                  state;
   logic [PC_WIDTH-1:0]     pc;
   logic [FLAG_WIDTH-1:0]   flags;
   logic [SPW-1:0]          sp;
   logic                    fault;
   logic                    ready;

   logic [2:0]              op_q;
   logic [FLAG_WIDTH-1:0]   check_q;
   logic [FLAG_WIDTH-1:0]   in_flags_q;
   logic [PC_WIDTH-1:0]     branch_q;

   logic [PC_WIDTH-1:0]     stack [STACK_DEPTH];

   logic                    accept;
   logic                    cond;
   logic                    full;
   logic                    empty;
   logic [PC_WIDTH-1:0]     pc1;
   logic [PC_WIDTH-1:0]     pc2;
   logic [PC_WIDTH-1:0]     pc_rel;
   logic [AW-1:0]           top_idx;
   logic [AW-1:0]           push_idx;

   logic [PC_WIDTH-1:0]     nxt_pc;
   logic [FLAG_WIDTH-1:0]   nxt_flags;
   logic [SPW-1:0]          nxt_sp;
   logic                    set_fault;
   logic                    push;

   assign accept   = rx_enable & rx_strobe & ready;
   assign cond     = ((flags & check_q) == check_q);
   assign full     = (sp == SPW'(STACK_DEPTH));
   assign empty    = (sp == '0);
   assign pc1      = pc + PC_WIDTH'(1);
   assign pc2      = pc + PC_WIDTH'(2);
   assign pc_rel   = pc + branch_q;
   assign top_idx  = AW'(sp - SPW'(1));
   assign push_idx = sp[AW-1:0];

   always_comb begin
      nxt_pc    = pc1;
      nxt_flags = flags;
      nxt_sp    = sp;
      set_fault = 1'b0;
      push      = 1'b0;
      case (op_q)
         OP_NOP:    nxt_pc = pc1;
         OP_WFLAGS: begin
            nxt_flags = in_flags_q;
            nxt_pc    = pc;
         end
         OP_JABS:   nxt_pc = cond ? branch_q : pc1;
         OP_JREL:   nxt_pc = cond ? pc_rel : pc1;
         OP_CALL: begin
            if (cond && !full) begin
               push   = 1'b1;
               nxt_sp = sp + SPW'(1);
               nxt_pc = branch_q;
            end else if (cond) begin
               set_fault = 1'b1;
            end
         end
         OP_RET: begin
            if (cond && !empty) begin
               nxt_sp = sp - SPW'(1);
               nxt_pc = stack[top_idx];
            end else if (cond) begin
               set_fault = 1'b1;
            end
         end
         OP_SKIP:   nxt_pc = cond ? pc2 : pc1;
         default:   set_fault = 1'b1;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state      <= IDLE;
         pc         <= '0;
         flags      <= '0;
         sp         <= '0;
         fault      <= 1'b0;
         ready      <= 1'b1;
         op_q       <= OP_NOP;
         check_q    <= '0;
         in_flags_q <= '0;
         branch_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q       <= rx_op;
                  check_q    <= rx_check_flags;
                  in_flags_q <= rx_input_flags;
                  branch_q   <= rx_branch;
                  ready      <= 1'b0;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               pc    <= nxt_pc;
               flags <= nxt_flags;
               sp    <= nxt_sp;
               fault <= fault | set_fault;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stack contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge aclk) begin
      if (state == EXEC && push) begin
         stack[push_idx] <= pc1;
      end
   end

   assign tx_program_counter = pc;
   assign tx_ready           = ready;
   assign tx_fault           = fault;

endmodule
